// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: RISC-V M-extension
// funct3 op order and the controller state enum.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and keep the subtraction only when it does not borrow.
module div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dsr_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // The partial remainder stays below the divisor, so W+1 bits hold the trial
  // difference and its top bit is the borrow.
  assign shifted = {rem_i, quo_i[W-1]};
  assign trial   = shifted - {1'b0, dsr_i};
  assign rem_o   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
  assign quo_o   = {quo_i[W-2:0], ~trial[W]};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32/RV64 M-extension unit: radix-2^MUL_STEP shift-add multiplier
// and a 1-bit/cycle restoring divider, both on operand magnitudes.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int MUL_STEP = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] fwd1,
  input  logic [XLEN-1:0] fwd2,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result_out
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN;

  muldiv_state_e   state_q, state_d;
  logic [2:0]      op_q;
  logic            word_q, negQuo_q, negRem_q, special_q;
  logic [4:0]      rd_q, rdOut_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   prod_q, mcand_q;
  logic [XLEN-1:0] mplier_q, rem_q, quo_q, dsr_q, res_q;

  logic            wordEff, signA, signB, divZero, divOvf, isSpecial, accept, lastIter;
  int              opLen;
  logic [CW-1:0]   cycles;
  logic [XLEN-1:0] nMask, topBit, aN, bN, magA, magB, specQuo, specRem;
  logic [PW-1:0]   prodNext, prodFin;
  logic [XLEN-1:0] remStep, quoStep, quoFin, remFin, mulRes, calcRes;

  function automatic logic [XLEN-1:0] sext_n(input logic [XLEN-1:0] v, input logic w);
    logic [XLEN-1:0] r;
    r = v;
    if (w) for (int i = 32; i < XLEN; i++) r[i] = v[31];
    return r;
  endfunction

  // Operand decode at accept: N-bit view of each operand, its sign, its magnitude.
  always_comb begin
    wordEff = word && (XLEN == 64);
    for (int i = 0; i < XLEN; i++) nMask[i] = !wordEff || (i < 32);
    topBit  = nMask & ~(nMask >> 1);
    aN      = fwd1 & nMask;
    bN      = fwd2 & nMask;
    signA   = (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM) &&
              ((aN & topBit) != '0);
    signB   = (op == OP_MULH || op == OP_DIV || op == OP_REM) && ((bN & topBit) != '0);
    magA    = signA ? ((-aN) & nMask) : aN;
    magB    = signB ? ((-bN) & nMask) : bN;
    divZero = (bN == '0);
    divOvf  = (op == OP_DIV || op == OP_REM) && (aN == topBit) && (bN == nMask);
    isSpecial = op[2] && (divZero || divOvf);
    specQuo = divZero ? '1 : sext_n(aN, wordEff);
    specRem = divZero ? sext_n(aN, wordEff) : '0;
    opLen   = wordEff ? 32 : XLEN;
    if (!op[2])         cycles = CW'(opLen / MUL_STEP);
    else if (isSpecial) cycles = CW'(1);
    else                cycles = CW'(opLen);
  end

  div_step #(.W(XLEN)) u_div_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dsr_i(dsr_q),
    .rem_o(remStep),
    .quo_o(quoStep)
  );

  // Per-iteration datapath; sign fixup is folded into the last CALC cycle.
  always_comb begin
    prodNext = prod_q + mcand_q * PW'(mplier_q[MUL_STEP-1:0]);
    prodFin  = negQuo_q ? -prodNext : prodNext;
    if (op_q == OP_MUL) mulRes = prodFin[XLEN-1:0];
    else if (word_q)    mulRes = XLEN'(prodFin[63:32]);
    else                mulRes = prodFin[PW-1:XLEN];
    quoFin   = special_q ? quo_q : (negQuo_q ? -quoStep : quoStep);
    remFin   = special_q ? rem_q : (negRem_q ? -remStep : remStep);
    calcRes  = op_q[2] ? sext_n(op_q[1] ? remFin : quoFin, word_q) : sext_n(mulRes, word_q);
    lastIter = (cnt_q == CW'(1));
  end

  assign accept = (state_q == IDLE) && in_valid && !clear;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (lastIter) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = !out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Word divides start with the 32-bit dividend left-aligned so the quotient
  // lands in the low 32 bits after 32 shifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      word_q    <= 1'b0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
      special_q <= 1'b0;
      rd_q      <= '0;
      rdOut_q   <= '0;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      res_q     <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q      <= op;
      word_q    <= wordEff;
      rd_q      <= rd;
      negQuo_q  <= signA ^ signB;
      negRem_q  <= signA;
      special_q <= isSpecial;
      cnt_q     <= cycles;
      prod_q    <= '0;
      mcand_q   <= PW'(magA);
      mplier_q  <= magB;
      dsr_q     <= magB;
      quo_q     <= isSpecial ? specQuo : (magA << (XLEN - opLen));
      rem_q     <= isSpecial ? specRem : '0;
    end else if (state_q == CALC) begin
      cnt_q    <= cnt_q - CW'(1);
      prod_q   <= prodNext;
      mcand_q  <= mcand_q << MUL_STEP;
      mplier_q <= mplier_q >> MUL_STEP;
      rem_q    <= remStep;
      quo_q    <= quoStep;
      if (lastIter) begin
        res_q   <= calcRes;
        rdOut_q <= rd_q;
      end
    end
  end

  assign result_out = res_q;
  assign rd_out     = rdOut_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=64, MUL_STEP=8): directed corner
// cases plus randomized operations against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk, rst_n, clear, in_valid, in_ready, word, busy, out_valid, out_ready;
  logic [2:0]  op;
  logic [4:0]  rd, rd_out;
  logic [63:0] fwd1, fwd2, result_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(64), .MUL_STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .rd(rd), .fwd1(fwd1), .fwd2(fwd2), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .rd_out(rd_out), .result_out(result_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model straight from the M-extension rules.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  ua, ub, sa, sb, q, rm, r;
    logic [127:0] pa, pb, p;
    if (w) begin
      ua = {32'b0, a[31:0]};          ub = {32'b0, b[31:0]};
      sa = {{32{a[31]}}, a[31:0]};    sb = {{32{b[31]}}, b[31:0]};
    end else begin
      ua = a; ub = b; sa = a; sb = b;
    end
    pa = (o == OP_MULH || o == OP_MULHSU) ? {{64{sa[63]}}, sa} : {64'b0, ua};
    pb = (o == OP_MULH) ? {{64{sb[63]}}, sb} : {64'b0, ub};
    p  = pa * pb;
    if (o == OP_DIV || o == OP_REM) begin
      if (sb == 64'd0) begin q = '1; rm = sa; end
      else if (sb == '1 && sa == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
        q = sa; rm = 64'd0;
      end else begin
        q  = $signed(sa) / $signed(sb);
        rm = $signed(sa) % $signed(sb);
      end
    end else begin
      if (ub == 64'd0) begin q = '1; rm = ua; end
      else begin q = ua / ub; rm = ua % ub; end
    end
    case (o)
      OP_MUL:                     r = w ? 64'(p[31:0]) : p[63:0];
      OP_MULH, OP_MULHSU, OP_MULHU: r = w ? 64'(p[63:32]) : p[127:64];
      OP_DIV, OP_DIVU:            r = q;
      default:                    r = rm;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic int exp_cycles(input logic [2:0] o, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    int n;
    logic [63:0] am, bm;
    n  = w ? 32 : 64;
    am = w ? {32'b0, a[31:0]} : a;
    bm = w ? {32'b0, b[31:0]} : b;
    if (o < OP_DIV) return n / 8;
    if (bm == 64'd0) return 1;
    if ((o == OP_DIV || o == OP_REM) && bm == (w ? 64'hFFFF_FFFF : '1) &&
        am == (w ? 64'h8000_0000 : 64'h8000_0000_0000_0000)) return 1;
    return n;
  endfunction

  // Issue one request and wait for out_valid; leaves the result in DONE.
  task automatic run_op(input logic [2:0] o, input logic w, input logic [4:0] t,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output logic [4:0] tag, output int cyc);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1; op = o; word = w; rd = t; fwd1 = a; fwd2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; fwd1 = {$urandom, $urandom}; fwd2 = {$urandom, $urandom}; rd = 5'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
    if (guard >= 100) cyc = -1;
    res = result_out;
    tag = rd_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (in_ready !== 1'b1)      begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0)     begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (rd_out !== 5'd0)        begin errors++; $display("[TB] FAIL reset_rd_out: got %0d expected 0", rd_out); end
    if (result_out !== 64'd0)   begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", result_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]  tOp  [8];
    logic        tW   [8];
    logic [63:0] tA   [8];
    logic [63:0] tB   [8];
    logic [63:0] tExp [8];
    int          tCyc [8];
    logic [63:0] res;
    logic [4:0]  tag;
    int          cyc;
    tOp  = '{OP_MUL, OP_MULHU, OP_DIV, OP_REM, OP_DIVU, OP_DIV, OP_REM, OP_DIVU};
    tW   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tA   = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9,
             64'h0000_0012_3456_789A, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
             64'h0000_0000_8000_0000};
    tB   = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd2, 64'd0,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    tExp = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
             64'd0, 64'hFFFF_FFFF_8000_0000};
    tCyc = '{8, 8, 64, 64, 1, 1, 1, 32};
    for (int i = 0; i < 8; i++) begin
      run_op(tOp[i], tW[i], 5'(i * 3), tA[i], tB[i], res, tag, cyc);
      checks += 3;
      if (res !== tExp[i]) begin errors++; $display("[TB] FAIL directed%0d_result: got %h expected %h", i, res, tExp[i]); end
      if (cyc != tCyc[i])  begin errors++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, cyc, tCyc[i]); end
      if (tag !== 5'(i * 3)) begin errors++; $display("[TB] FAIL directed%0d_rd: got %0d expected %0d", i, tag, i * 3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic        w;
    logic [4:0]  t;
    logic [63:0] a, b, exp, res;
    logic [4:0]  tag;
    int          cyc, sel, ecyc;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom);
      t = 5'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      if (sel == 0) b = w ? {$urandom, 32'd0} : 64'd0;
      else if (sel == 1) begin
        a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
      end else if (sel == 2) begin
        a = 64'($signed($urandom_range(0, 200)) - 100);
        b = 64'($signed($urandom_range(0, 20)) - 10);
      end
      exp  = ref_model(o, w, a, b);
      ecyc = exp_cycles(o, w, a, b);
      run_op(o, w, t, a, b, res, tag, cyc);
      checks += 3;
      if (res !== exp) begin errors++; $display("[TB] FAIL random%0d_result op=%0d w=%b a=%h b=%h: got %h expected %h", i, o, w, a, b, res, exp); end
      if (cyc != ecyc) begin errors++; $display("[TB] FAIL random%0d_latency op=%0d w=%b: got %0d expected %0d", i, o, w, cyc, ecyc); end
      if (tag !== t)   begin errors++; $display("[TB] FAIL random%0d_rd: got %0d expected %0d", i, tag, t); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    logic [4:0]  tag;
    int          cyc;
    run_op(OP_MULHSU, 1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, res, tag, cyc);
    checks += 3;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL b2b_first_result: got %h expected ffffffffffffffff", res); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_in_ready: got %b expected 0", in_ready); end
    if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL b2b_done_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (!(in_ready === 1'b1 && out_valid === 1'b0)) begin
      errors++; $display("[TB] FAIL b2b_idle: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    run_op(OP_REMU, 1'b1, 5'd6, 64'h1234_5678_FFFF_FFF0, 64'h0000_0000_0000_0007, res, tag, cyc);
    checks += 2;
    if (res !== 64'hFFFF_FFFF_FFFF_FFF0 % 64'd1 + 64'd0 + 64'(32'hFFFF_FFF0 % 32'd7)) begin
      errors++; $display("[TB] FAIL b2b_second_result: got %h expected %h", res, 64'(32'hFFFF_FFF0 % 32'd7));
    end
    if (cyc != 32) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected 32", cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [63:0] res, exp;
    logic [4:0]  tag;
    int          cyc;
    exp = ref_model(OP_MULH, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'h8765_4321_FEDC_BA98);
    out_ready = 1'b0;
    run_op(OP_MULH, 1'b0, 5'd17, 64'hDEAD_BEEF_0123_4567, 64'h8765_4321_FEDC_BA98, res, tag, cyc);
    checks++;
    if (res !== exp) begin errors++; $display("[TB] FAIL stall_result: got %h expected %h", res, exp); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks += 2;
      if (!(out_valid === 1'b1 && result_out === exp && rd_out === 5'd17)) begin
        errors++; $display("[TB] FAIL stall_hold%0d: got valid=%b res=%h rd=%0d expected 1 %h 17", i, out_valid, result_out, rd_out, exp);
      end
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_busy%0d: got %b expected 1", i, busy); end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_clear();
    logic [63:0] res;
    logic [4:0]  tag;
    int          cyc, seen;
    in_valid = 1'b1; op = OP_DIV; word = 1'b0; rd = 5'd9;
    fwd1 = 64'hFFFF_FFFF_FFFF_FFF9; fwd2 = 64'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL clear_calc_busy: got %b expected 1", busy); end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks += 2;
    if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL clear_idle: got in_ready=%b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_out_valid: got %b expected 0", out_valid); end
    seen = 0;
    repeat (70) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL clear_no_result: got %0d valid cycles expected 0", seen); end
    in_valid = 1'b1; clear = 1'b1; op = OP_MUL; fwd1 = 64'd5; fwd2 = 64'd5;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    checks++;
    if (!(in_ready === 1'b1 && busy === 1'b0)) begin
      errors++; $display("[TB] FAIL clear_beats_valid: got in_ready=%b busy=%b expected 1 0", in_ready, busy);
    end
    run_op(OP_MUL, 1'b0, 5'd3, 64'd3, 64'd4, res, tag, cyc);
    checks += 2;
    if (res !== 64'd12) begin errors++; $display("[TB] FAIL clear_next_mul: got %h expected 000000000000000c", res); end
    if (cyc != 8)       begin errors++; $display("[TB] FAIL clear_next_latency: got %0d expected 8", cyc); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(OP_DIVU, 1'b0, 5'd4, 64'd100, 64'd0, res, tag, cyc);
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (!(out_valid === 1'b0 && in_ready === 1'b1)) begin
      errors++; $display("[TB] FAIL clear_in_done: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    in_valid = 1'b1; op = OP_DIVU; word = 1'b0; rd = 5'd21;
    fwd1 = 64'd1000; fwd2 = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; clear = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_state: got valid=%b busy=%b expected 0 0", out_valid, busy); end
    if (result_out !== 64'd0) begin errors++; $display("[TB] FAIL midreset_result: got %h expected 0", result_out); end
    if (rd_out !== 5'd0)      begin errors++; $display("[TB] FAIL midreset_rd: got %0d expected 0", rd_out); end
    seen = 0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL midreset_no_result: got %0d valid cycles expected 0", seen); end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; op = 3'd0; word = 1'b0; rd = 5'd0;
    fwd1 = 64'd0; fwd2 = 64'd0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_stall();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
